// File: rtl/normalize_rnd_pipe_if.sv
// Stream interface for the mantissa normaliser: input handshake plus data, output handshake plus result.
interface normalize_rnd_pipe_if #(
    parameter int WIDIN  = 48,
    parameter int WIDOUT = 23,
    parameter int BIASD  = 8
);
    logic              i_vld;
    logic              i_rdy;
    logic [WIDIN-1:0]  i_nori;
    logic              i_rnd;
    logic              o_vld;
    logic              o_rdy;
    logic [WIDOUT-1:0] o_noro;
    logic [BIASD-1:0]  o_bias;
    logic              o_zero;
    logic              o_inex;

    modport slave (
        input  i_vld, i_nori, i_rnd, o_rdy,
        output i_rdy, o_vld, o_noro, o_bias, o_zero, o_inex
    );

    modport master (
        output i_vld, i_nori, i_rnd, o_rdy,
        input  i_rdy, o_vld, o_noro, o_bias, o_zero, o_inex
    );
endinterface

// File: rtl/normalize_rnd_pipe.sv
// Three-stage leading-one normaliser with truncate / round-nearest-even, exponent bias term and
// zero/inexact flags; one global advance enable stalls the whole pipe under output backpressure.
module normalize_rnd_pipe #(
    parameter int WIDIN  = 48,
    parameter int WIDOUT = 23,
    parameter int BIASD  = 8,
    parameter int BIAS0  = 126
) (
    input  logic                 clk,
    input  logic                 rst,
    normalize_rnd_pipe_if.slave  bus
);
    localparam int LZW = $clog2(WIDIN + 1);
    localparam int SEW = WIDIN - 1 + WIDOUT;

    logic adv;
    assign adv       = ~bus.o_vld | bus.o_rdy;
    assign bus.i_rdy = adv;

    // Highest set bit wins because the loop scans upward; all-zero leaves lzc = WIDIN.
    logic [LZW-1:0] lzc;
    always_comb begin
        lzc = LZW'(WIDIN);
        for (int i = 0; i < WIDIN; i++) begin
            if (bus.i_nori[i]) lzc = LZW'(WIDIN - 1 - i);
        end
    end

    logic             v1, r1;
    logic [WIDIN-1:0] d1;
    logic [LZW-1:0]   lzc1;

    // Hidden bit is dropped; zero padding below bit 0 covers the narrow-input case.
    logic [WIDIN-1:0]  s;
    logic [SEW-1:0]    se;
    logic [WIDOUT-1:0] frac_c;
    logic              guard_c, sticky_c, zero_c;
    logic [BIASD-1:0]  bias_c;
    always_comb begin
        s        = d1 << lzc1;
        se       = {s[WIDIN-2:0], {WIDOUT{1'b0}}};
        frac_c   = se[SEW-1 -: WIDOUT];
        guard_c  = se[WIDIN-2];
        sticky_c = |se[WIDIN-3:0];
        zero_c   = ~s[WIDIN-1];
        bias_c   = BIASD'(BIAS0) + BIASD'(lzc1);
    end

    logic              v2, r2, g2, st2, z2;
    logic [WIDOUT-1:0] frac2;
    logic [BIASD-1:0]  bias2;

    logic              up;
    logic [WIDOUT:0]   sum;
    logic              wrap;
    always_comb begin
        up   = r2 & g2 & (st2 | frac2[0]);
        sum  = {1'b0, frac2} + (WIDOUT+1)'(up);
        wrap = sum[WIDOUT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            r1         <= 1'b0;
            d1         <= '0;
            lzc1       <= '0;
            v2         <= 1'b0;
            r2         <= 1'b0;
            g2         <= 1'b0;
            st2        <= 1'b0;
            z2         <= 1'b0;
            frac2      <= '0;
            bias2      <= '0;
            bus.o_vld  <= 1'b0;
            bus.o_noro <= '0;
            bus.o_bias <= '0;
            bus.o_zero <= 1'b0;
            bus.o_inex <= 1'b0;
        end else if (adv) begin
            v1   <= bus.i_vld;
            r1   <= bus.i_rnd;
            d1   <= bus.i_nori;
            lzc1 <= lzc;

            v2    <= v1;
            r2    <= r1;
            g2    <= guard_c;
            st2   <= sticky_c;
            z2    <= zero_c;
            frac2 <= frac_c;
            bias2 <= bias_c;

            // A carry out of the fraction means the mantissa became 2.0: fraction 0, one less leading zero.
            bus.o_vld  <= v2;
            bus.o_noro <= wrap ? '0 : sum[WIDOUT-1:0];
            bus.o_bias <= bias2 - BIASD'(wrap);
            bus.o_zero <= z2;
            bus.o_inex <= g2 | st2;
        end
    end
endmodule

// File: tb/tb_normalize_rnd_pipe.sv
// Randomised and directed bench for normalize_rnd_pipe with an arithmetic reference model and scoreboard.
module tb_normalize_rnd_pipe;
    localparam int WIDIN  = 48;
    localparam int WIDOUT = 23;
    localparam int BIASD  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    normalize_rnd_pipe_if #(.WIDIN(WIDIN), .WIDOUT(WIDOUT), .BIASD(BIASD)) bus();

    normalize_rnd_pipe #(.WIDIN(WIDIN), .WIDOUT(WIDOUT), .BIASD(BIASD), .BIAS0(126)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [22:0] noro;
        logic [7:0]  bias;
        logic        zero;
        logic        inex;
        int          t_in;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cycle = 0;
    bit          lat_chk = 0;
    bit          held = 0;
    logic [22:0] h_noro;
    logic [7:0]  h_bias;
    logic        h_zero, h_inex;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    function automatic exp_t mk(input logic [22:0] noro, input logic [7:0] bias,
                                input logic zero, input logic inex);
        exp_t e;
        e.noro = noro; e.bias = bias; e.zero = zero; e.inex = inex; e.t_in = 0;
        return e;
    endfunction

    // Value x with leading one at p: mantissa = x*2^23 / 2^p in [2^23, 2^24), remainder decides rounding.
    function automatic exp_t model(input logic [47:0] x, input logic rnd);
        exp_t e;
        int p;
        logic [127:0] num, q, rem, half;
        if (x == 0) return mk(23'h0, 8'(126 + 48), 1'b1, 1'b0);
        p = -1;
        for (int i = 0; i < 48; i++) if (x[i]) p = i;
        num  = 128'(x) << 23;
        q    = num >> p;
        rem  = num - (q << p);
        half = (p == 0) ? 128'd0 : (128'd1 << (p - 1));
        e = mk(23'h0, 8'(126 + 47 - p), 1'b0, rem != 0);
        if (rnd && rem != 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (q == (128'd1 << 24)) e.bias = e.bias - 8'd1;
        else                     e.noro = q[22:0];
        return e;
    endfunction

    task automatic cyc(input logic vld, input logic [47:0] d, input logic rnd, input logic ordy,
                       input bit use_ov, input exp_t ov, output bit fired);
        exp_t e;
        @(negedge clk);
        bus.i_vld  = vld;
        bus.i_nori = d;
        bus.i_rnd  = rnd;
        bus.o_rdy  = ordy;
        #1;
        cycle++;
        if (held) begin
            check("hold_vld",  bus.o_vld,  1'b1);
            check("hold_noro", bus.o_noro, h_noro);
            check("hold_bias", bus.o_bias, h_bias);
            check("hold_zero", bus.o_zero, h_zero);
            check("hold_inex", bus.o_inex, h_inex);
        end
        check("i_rdy", bus.i_rdy, !bus.o_vld || ordy);
        if (bus.o_vld && bus.o_rdy) begin
            if (sb.size() == 0) check("spurious_out", 1, 0);
            else begin
                e = sb.pop_front();
                check("noro", bus.o_noro, e.noro);
                check("bias", bus.o_bias, e.bias);
                check("zero", bus.o_zero, e.zero);
                check("inex", bus.o_inex, e.inex);
                if (lat_chk) check("latency", cycle - e.t_in, 3);
            end
        end
        fired = vld && bus.i_rdy;
        if (fired) begin
            e = use_ov ? ov : model(d, rnd);
            e.t_in = cycle;
            sb.push_back(e);
        end
        held   = bus.o_vld && !ordy;
        h_noro = bus.o_noro;
        h_bias = bus.o_bias;
        h_zero = bus.o_zero;
        h_inex = bus.o_inex;
    endtask

    task automatic send_dir(input logic [47:0] d, input logic rnd, input exp_t e);
        bit f;
        cyc(1'b1, d, rnd, 1'b1, 1, e, f);
        check("accept", f, 1);
    endtask

    task automatic idle(input int n);
        bit f;
        exp_t z;
        z = mk(0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc(1'b0, 48'h0, 1'b0, 1'b1, 0, z, f);
    endtask

    task automatic drain();
        bit f;
        exp_t z;
        int n;
        z = mk(0, 0, 0, 0);
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            cyc(1'b0, 48'h0, 1'b0, 1'b1, 0, z, f);
            n++;
        end
        check("drain_left", sb.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        bus.i_vld  = 1'b1;
        bus.i_nori = 48'h0000_1234_5678;
        bus.o_rdy  = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.i_vld = 1'b0;
        sb.delete();
        held = 0;
        #1;
        check("rst_o_vld",  bus.o_vld,  0);
        check("rst_o_noro", bus.o_noro, 0);
        check("rst_o_bias", bus.o_bias, 0);
        check("rst_o_zero", bus.o_zero, 0);
        check("rst_o_inex", bus.o_inex, 0);
        check("rst_i_rdy",  bus.i_rdy,  1);
    endtask

    function automatic logic [47:0] rnd_data();
        logic [63:0] r;
        logic [47:0] v;
        int k;
        r = {$urandom, $urandom};
        v = r[47:0];
        k = $urandom_range(0, 9);
        if (k == 0) return 48'h0;
        if (k == 1) v = {1'b1, v[46:24], 1'b1, 23'h0};
        if (k == 2) v = {1'b1, 23'h7FFFFF, v[23:0]};
        return v >> $urandom_range(0, 47);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        bit   f;
        int   k, guard_n;
        exp_t z;
        logic [47:0] items[8];
        logic [47:0] d;

        z = mk(0, 0, 0, 0);
        bus.i_vld = 1'b0; bus.i_nori = '0; bus.i_rnd = 1'b1; bus.o_rdy = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed values with fixed latency of 3 under free-flowing output.
        lat_chk = 1;
        send_dir(48'h8000_0000_0000, 1'b1, mk(23'h0, 8'd126, 1'b0, 1'b0));
        send_dir(48'h0000_0000_0001, 1'b1, mk(23'h0, 8'd173, 1'b0, 1'b0));
        send_dir(48'h0,              1'b1, mk(23'h0, 8'd174, 1'b1, 1'b0));
        send_dir({1'b1, 23'h7FFFFF, 1'b1, 23'h0}, 1'b1, mk(23'h0, 8'd125, 1'b0, 1'b1));
        send_dir({1'b1, 23'h7FFFFF, 1'b1, 23'h0}, 1'b0, mk(23'h7FFFFF, 8'd126, 1'b0, 1'b1));
        send_dir({1'b1, 23'h000002, 1'b1, 23'h0}, 1'b1, mk(23'h000002, 8'd126, 1'b0, 1'b1));
        send_dir({1'b1, 23'h000003, 1'b1, 23'h0}, 1'b1, mk(23'h000004, 8'd126, 1'b0, 1'b1));
        send_dir(48'h0000_0180_0001, 1'b0, mk(23'h400000, 8'd149, 1'b0, 1'b1));
        drain();
        lat_chk = 0;

        // Eight back-to-back items with a four-cycle output stall in the middle.
        for (int i = 0; i < 8; i++) items[i] = rnd_data() | 48'h1;
        k = 0;
        guard_n = 0;
        while (k < 8 && guard_n < 40) begin
            cyc(1'b1, items[k], 1'b1, !(guard_n >= 4 && guard_n < 8), 0, z, f);
            if (f) k++;
            guard_n++;
        end
        check("burst_sent", k, 8);
        drain();

        // Reset with three items in flight discards them.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 48'h0000_0F00_0000 + 48'(i), 1'b1, 1'b1, 0, z, f);
        end
        do_reset();
        idle(5);
        lat_chk = 1;
        send_dir(48'h0000_0000_8001, 1'b1, model(48'h0000_0000_8001, 1'b1));
        drain();
        lat_chk = 0;

        // Random traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            d = rnd_data();
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 7, 0, z, f);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
